// File: rtl/decoder_scan_ctrl.sv
// Round-robin scan controller driving the select/enable of decoder2to4.
// Define SCAN_BLANK_EN to insert BLANK en-low cycles before every dwell.
module decoder_scan_ctrl #(
    parameter int DIV_W = 8,
    parameter int BLANK = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [DIV_W-1:0] div,
    input  logic [3:0]       mask,
    output logic             A,
    output logic             B,
    output logic             en,
    output logic             slot_start,
    output logic             frame_done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BLANK,
        S_DWELL
    } state_t;

`ifdef SCAN_BLANK_EN
    localparam int NBLANK = BLANK;
    localparam int BW = (BLANK > 1) ? $clog2(BLANK) : 1;
    localparam logic [BW-1:0] B_LAST = BW'((BLANK > 0) ? BLANK - 1 : 0);
    logic [BW-1:0] bcnt;
    logic [BW-1:0] bcnt_d;
`else
    // BLANK has no effect without the blanking build
    localparam int NBLANK = BLANK * 0;
`endif
    localparam logic HAS_BLANK = (NBLANK > 0);

    state_t           state;
    state_t           state_d;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] cnt_d;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    logic [1:0]       sel;
    logic [1:0]       sel_d;
    logic             en_d;
    logic             ss_d;
    logic             fd_d;
    logic [1:0]       low_slot;
    logic [1:0]       nxt_slot;
    logic             start;
    logic             dwell_end;
    logic             cont;

    assign start     = (state == S_IDLE) && run && (|mask);
    assign dwell_end = (state == S_DWELL) && (cnt == div_q);
    assign cont      = dwell_end && run && (|mask);

    always_comb begin
        low_slot = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (mask[i]) low_slot = 2'(i);
        end
    end

    // Search sel+1 .. sel+4; the smallest offset wins, sel+4 wraps to sel.
    always_comb begin
        nxt_slot = sel;
        for (int k = 4; k >= 1; k--) begin
            if (mask[sel + 2'(k)]) nxt_slot = sel + 2'(k);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            div_q      <= '0;
            sel        <= 2'd0;
            en         <= 1'b0;
            slot_start <= 1'b0;
            frame_done <= 1'b0;
`ifdef SCAN_BLANK_EN
            bcnt       <= '0;
`endif
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            div_q      <= div_d;
            sel        <= sel_d;
            en         <= en_d;
            slot_start <= ss_d;
            frame_done <= fd_d;
`ifdef SCAN_BLANK_EN
            bcnt       <= bcnt_d;
`endif
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        div_d   = div_q;
`ifdef SCAN_BLANK_EN
        bcnt_d  = bcnt;
`endif
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    if (HAS_BLANK) begin
                        state_d = S_BLANK;
`ifdef SCAN_BLANK_EN
                        bcnt_d  = '0;
`endif
                    end else begin
                        state_d = S_DWELL;
                        cnt_d   = '0;
                        div_d   = div;
                    end
                end
            end
            S_BLANK: begin
`ifdef SCAN_BLANK_EN
                if (bcnt == B_LAST) begin
                    state_d = S_DWELL;
                    cnt_d   = '0;
                    div_d   = div;
                end else begin
                    bcnt_d = bcnt + 1'b1;
                end
`else
                state_d = S_DWELL;
`endif
            end
            S_DWELL: begin
                if (!dwell_end) begin
                    cnt_d = cnt + 1'b1;
                end else if (!cont) begin
                    state_d = S_IDLE;
                end else if (HAS_BLANK) begin
                    state_d = S_BLANK;
`ifdef SCAN_BLANK_EN
                    bcnt_d  = '0;
`endif
                end else begin
                    cnt_d = '0;
                    div_d = div;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        sel_d = sel;
        if (start) begin
            sel_d = low_slot;
        end else if (cont) begin
            sel_d = nxt_slot;
        end
        en_d = (state_d == S_DWELL);
        ss_d = en_d && ((state != S_DWELL) || dwell_end);
        fd_d = cont && (nxt_slot <= sel);
    end

    assign A = sel[1];
    assign B = sel[0];

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Directed bench for decoder_scan_ctrl; expectations follow the
// SCAN_BLANK_EN setting used for the build (BLANK = 2 when enabled).
module tb_decoder_scan_ctrl;

`ifdef SCAN_BLANK_EN
    localparam int NB = 2;
`else
    localparam int NB = 0;
`endif

    logic       clk;
    logic       rst_n;
    logic       run;
    logic [7:0] div;
    logic [3:0] mask;
    logic       A;
    logic       B;
    logic       en;
    logic       slot_start;
    logic       frame_done;
    logic [4:0] obs;

    int n_chk;
    int n_err;

    decoder_scan_ctrl #(
        .DIV_W(8),
        .BLANK(2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (run),
        .div       (div),
        .mask      (mask),
        .A         (A),
        .B         (B),
        .en        (en),
        .slot_start(slot_start),
        .frame_done(frame_done)
    );

    assign obs = {A, B, en, slot_start, frame_done};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [4:0] got,
                       input logic [4:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got {A,B,en,ss,fd}=%b expected %b",
                     tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One slot: NB blank cycles then d dwell cycles (d may be partial).
    task automatic expect_slot(input logic [1:0] s, input int d,
                               input bit fd);
        for (int i = 0; i < NB; i++) begin
            tick();
            chk($sformatf("blank s%0d c%0d", s, i), obs,
                {s, 1'b0, 1'b0, fd && (i == 0)});
        end
        for (int i = 0; i < d; i++) begin
            tick();
            chk($sformatf("dwell s%0d c%0d", s, i), obs,
                {s, 1'b1, (i == 0), fd && (i == 0) && (NB == 0)});
        end
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst_n = 1'b0;
        run   = 1'b0;
        div   = 8'd0;
        mask  = 4'h0;
        #12;
        chk("reset", obs, 5'b00000);
        rst_n = 1'b1;
        tick();
        chk("idle no run", obs, 5'b00000);

        // full scan, 4-cycle dwells
        run  = 1'b1;
        mask = 4'hF;
        div  = 8'd3;
        expect_slot(2'd0, 4, 1'b0);
        expect_slot(2'd1, 4, 1'b0);
        expect_slot(2'd2, 4, 1'b0);
        expect_slot(2'd3, 4, 1'b0);
        expect_slot(2'd0, 4, 1'b1);

        // sparse mask, 1-cycle dwells
        mask = 4'b1010;
        div  = 8'd0;
        expect_slot(2'd1, 1, 1'b0);
        expect_slot(2'd3, 1, 1'b0);
        expect_slot(2'd1, 1, 1'b1);
        expect_slot(2'd3, 1, 1'b0);
        expect_slot(2'd1, 1, 1'b1);

        // single slot repeats with a wrap every period
        mask = 4'b0100;
        div  = 8'd1;
        expect_slot(2'd2, 2, 1'b0);
        expect_slot(2'd2, 2, 1'b1);
        expect_slot(2'd2, 2, 1'b1);

        // stop mid-dwell; div change inside the dwell is ignored
        mask = 4'hF;
        div  = 8'd3;
        expect_slot(2'd3, 1, 1'b0);
        div = 8'd0;
        tick();
        chk("stop c1", obs, 5'b11100);
        run = 1'b0;
        tick();
        chk("stop c2", obs, 5'b11100);
        tick();
        chk("stop c3", obs, 5'b11100);
        tick();
        chk("stop idle0", obs, 5'b11000);
        tick();
        chk("stop idle1", obs, 5'b11000);

        // run with empty mask stays idle
        run  = 1'b1;
        mask = 4'h0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("mask0 c%0d", i), obs, 5'b11000);
        end

        // restart from idle at lowest enabled slot
        mask = 4'b1000;
        expect_slot(2'd3, 1, 1'b0);
        expect_slot(2'd3, 1, 1'b1);

        // maximum dwell length
        mask = 4'b0001;
        div  = 8'd255;
        expect_slot(2'd0, 256, 1'b1);
        expect_slot(2'd0, 3, 1'b1);

        // asynchronous reset mid-dwell
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset", obs, 5'b00000);
        #4;
        rst_n = 1'b1;
        run   = 1'b0;
        tick();
        chk("post reset idle", obs, 5'b00000);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
